// File: rtl/conv1d_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : conv1d_pkg
//  Purpose  : Shared constants and types for the conv1d 5-tap datapath:
//             tap count, tap mux select encoding and the sequencer state type.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package conv1d_pkg;

    localparam int NTAPS = 5;
    localparam int SEL_W = 3;

    // Select codes: SEL_FIRST addresses tap1 and counts down to 3'b000 (tap5).
    // SEL_IDLE is the only other code ever driven; the mux decodes it to 0.
    localparam logic [SEL_W-1:0] SEL_IDLE  = 3'b111;
    localparam logic [SEL_W-1:0] SEL_FIRST = 3'b100;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        WAIT_IN = 3'd2,
        MAC     = 3'd3,
        OUT     = 3'd4,
        DONE    = 3'd5
    } conv1d_seq_state_e;

endpackage
`default_nettype wire

// File: rtl/conv1d_tap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : conv1d_tap_sequencer
//  Purpose  : Sequences the conv1d 5-tap datapath. Warms up the sample window
//             with NTAPS-1 samples, then for every output takes one sample,
//             clears the MAC, walks the tap mux select over all taps while
//             accumulating, and presents the result with a valid/ready
//             handshake. A job of len_i outputs runs under start/busy/done.
//  Ports    : clk_i, rst_i (async, active-high)
//             start_i, len_i            job request (sampled in IDLE only)
//             busy_o, done_o            job status / one-cycle end pulse
//             in_valid_i, in_ready_o    sample handshake
//             shift_en_o                shift accepted sample into window
//             sel_o                     tap mux select (SEL_IDLE when unused)
//             acc_clr_o, acc_en_o       MAC control
//             out_valid_o, out_ready_i  result handshake
//  Revision : 1.0  initial release
// ============================================================================
module conv1d_tap_sequencer
    import conv1d_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             shift_en_o,
    output logic [SEL_W-1:0] sel_o,
    output logic             acc_clr_o,
    output logic             acc_en_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    // Last warm-up handshake index and last tap index.
    localparam logic [1:0] c_FILL_LAST = 2'(NTAPS - 2);
    localparam logic [2:0] c_TAP_LAST  = 3'(NTAPS - 1);

    conv1d_seq_state_e r_state;
    conv1d_seq_state_e w_state_nxt;

    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_out_cnt;
    logic [LEN_W-1:0] w_out_cnt_inc;
    logic [1:0]       r_fill_cnt;
    logic [2:0]       r_tap_cnt;

    logic w_in_ready;
    logic w_shift;
    logic w_out_last;

    // Ready is a pure state decode so there is no path from in_valid_i.
    assign w_in_ready    = (r_state == FILL) || (r_state == WAIT_IN);
    assign w_shift       = in_valid_i && w_in_ready;
    assign w_out_cnt_inc = r_out_cnt + LEN_W'(1);
    // Exact-width compare: len = 2^LEN_W-1 ends on the last count without wrap.
    assign w_out_last    = (w_out_cnt_inc == r_len);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    // A zero-length job goes straight to DONE without touching the window.
                    w_state_nxt = (len_i != '0) ? FILL : DONE;
                end
            end
            FILL: begin
                if (w_shift && (r_fill_cnt == c_FILL_LAST)) begin
                    w_state_nxt = WAIT_IN;
                end
            end
            WAIT_IN: begin
                if (w_shift) begin
                    w_state_nxt = MAC;
                end
            end
            MAC: begin
                if (r_tap_cnt == c_TAP_LAST) begin
                    w_state_nxt = OUT;
                end
            end
            OUT: begin
                if (out_ready_i) begin
                    w_state_nxt = w_out_last ? DONE : WAIT_IN;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Job length latch and fill / tap / output counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_len      <= '0;
            r_out_cnt  <= '0;
            r_fill_cnt <= '0;
            r_tap_cnt  <= '0;
        end else begin
            if ((r_state == IDLE) && start_i) begin
                r_len      <= len_i;
                r_out_cnt  <= '0;
                r_fill_cnt <= '0;
            end

            if ((r_state == FILL) && w_shift) begin
                r_fill_cnt <= r_fill_cnt + 2'd1;
            end

            if (r_state == WAIT_IN) begin
                r_tap_cnt <= '0;
            end else if (r_state == MAC) begin
                r_tap_cnt <= r_tap_cnt + 3'd1;
            end

            if ((r_state == OUT) && out_ready_i) begin
                r_out_cnt <= w_out_cnt_inc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from the state register only, except shift_en_o and
    // acc_clr_o which follow the sample handshake in the same cycle.
    // ------------------------------------------------------------------
    assign busy_o      = (r_state != IDLE);
    assign done_o      = (r_state == DONE);
    assign in_ready_o  = w_in_ready;
    assign shift_en_o  = w_shift;
    assign acc_clr_o   = (r_state == WAIT_IN) && in_valid_i;
    assign acc_en_o    = (r_state == MAC);
    assign out_valid_o = (r_state == OUT);
    // tap_cnt is 0..4 in MAC, so the select stays within 3'b100..3'b000.
    assign sel_o       = (r_state == MAC) ? (SEL_FIRST - r_tap_cnt) : SEL_IDLE;

endmodule
`default_nettype wire

// File: tb/tb_conv1d_tap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv1d_tap_sequencer
//  Purpose  : Self-checking bench for conv1d_tap_sequencer. Each MAC-starting
//             sample handshake pushes the cycle at which its result must
//             become valid; results popped on the output handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv1d_tap_sequencer;

    localparam int LEN_W = 16;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [LEN_W-1:0] len_i;
    logic             busy_o;
    logic             done_o;
    logic             in_valid_i;
    logic             in_ready_o;
    logic             shift_en_o;
    logic [2:0]       sel_o;
    logic             acc_clr_o;
    logic             acc_en_o;
    logic             out_valid_o;
    logic             out_ready_i;

    conv1d_tap_sequencer #(.LEN_W(LEN_W)) u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .len_i       (len_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .shift_en_o  (shift_en_o),
        .sel_o       (sel_o),
        .acc_clr_o   (acc_clr_o),
        .acc_en_o    (acc_en_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Stimulus modes: 0 = level, 1 = random, 2 = 10-cycle stall per result (ready only)
    int valid_mode = 0;
    int valid_lvl  = 1;
    int ready_mode = 0;
    int ready_lvl  = 1;
    int stall_drv  = 0;

    // Monitor / scoreboard state
    int exp_q[$];
    int starts[$];
    int mac_left    = 0;
    int job_samples = 0;
    int job_outs    = 0;
    int ov_start    = 0;
    int stall_cnt   = 0;
    int last_stall  = -1;
    int done_cyc    = 0;
    int done_count  = 0;
    int exp_t;
    bit ov_pending  = 0;
    bit prev_done   = 0;
    bit done_seen   = 0;

    initial begin
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (valid_mode == 1) in_valid_i = 1'($urandom_range(0, 1));
            else                 in_valid_i = (valid_lvl != 0);
            if (ready_mode == 1) begin
                out_ready_i = 1'($urandom_range(0, 1));
            end else if (ready_mode == 2) begin
                if (out_valid_o && stall_drv < 10) begin
                    out_ready_i = 1'b0;
                    stall_drv++;
                end else if (out_valid_o) begin
                    out_ready_i = 1'b1;
                    stall_drv   = 0;
                end else begin
                    out_ready_i = 1'b0;
                end
            end else begin
                out_ready_i = (ready_lvl != 0);
            end
        end
    end

    always @(negedge clk_i) begin
        if (rst_i) begin
            mac_left   = 0;
            exp_q.delete();
            ov_pending = 0;
            prev_done  = 0;
        end else begin
            if (in_valid_i) chk("shift_en", 32'(shift_en_o), 32'(in_ready_o));
            else if (shift_en_o) chk("shift_en_no_valid", 32'(shift_en_o), 0);

            if (shift_en_o || acc_clr_o)
                chk("acc_clr", 32'(acc_clr_o), 32'(shift_en_o && job_samples >= 4));

            if (mac_left > 0) begin
                chk("sel", 32'(sel_o), 32'(mac_left - 1));
                chk("acc_en", 32'(acc_en_o), 1);
                mac_left--;
            end else begin
                chk("sel_idle", 32'(sel_o), 7);
                chk("acc_en_idle", 32'(acc_en_o), 0);
            end

            if (acc_clr_o && shift_en_o) begin
                mac_left = 5;
                exp_q.push_back(cyc + 6);
            end
            if (shift_en_o) job_samples++;

            if (out_valid_o) begin
                chk("in_ready_during_out", 32'(in_ready_o), 0);
                if (!ov_pending) begin
                    ov_pending = 1;
                    ov_start   = cyc;
                    stall_cnt  = 0;
                end
                if (out_ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", 32'(exp_q.size()), 1);
                    end else begin
                        exp_t = exp_q.pop_front();
                        chk("out_latency", 32'(ov_start), 32'(exp_t));
                    end
                    starts.push_back(ov_start);
                    job_outs++;
                    last_stall = stall_cnt;
                    ov_pending = 0;
                end else begin
                    stall_cnt++;
                end
            end

            if (done_o) begin
                chk("done_pulse", 32'(prev_done), 0);
                chk("q_empty_at_done", 32'(exp_q.size()), 0);
                chk("busy_in_done", 32'(busy_o), 1);
                done_seen = 1;
                done_cyc  = cyc;
                done_count++;
            end
            prev_done = done_o;
        end
    end

    task automatic run_job(input int len, input int exp_dur, input bit chk_space,
                           input int exp_stall, input bit poke);
        int t0;
        bit got;
        @(posedge clk_i);
        #1;
        job_samples = 0;
        job_outs    = 0;
        done_seen   = 0;
        last_stall  = -1;
        starts.delete();
        start_i = 1'b1;
        len_i   = LEN_W'(len);
        t0      = cyc;
        got     = 0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk_i);
            #1;
            start_i = (poke && i == 8);
            if (poke && i == 8) len_i = LEN_W'(9);
            if (done_seen) begin
                got = 1;
                break;
            end
        end
        start_i = 1'b0;
        chk("job_done", 32'(got), 1);
        if (got) begin
            if (exp_dur >= 0) chk("job_duration", 32'(done_cyc - t0), 32'(exp_dur));
            chk("samples", 32'(job_samples), 32'((len == 0) ? 0 : len + 4));
            chk("outputs", 32'(job_outs), 32'(len));
            if (chk_space)
                for (int k = 1; k < starts.size(); k++)
                    chk("out_spacing", 32'(starts[k] - starts[k-1]), 7);
            if (exp_stall >= 0) chk("out_stall", 32'(last_stall), 32'(exp_stall));
        end
        chk("busy_after_job", 32'(busy_o), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},      32'(busy_o), 0);
        chk({tag, "_done"},      32'(done_o), 0);
        chk({tag, "_in_ready"},  32'(in_ready_o), 0);
        chk({tag, "_acc_clr"},   32'(acc_clr_o), 0);
        chk({tag, "_acc_en"},    32'(acc_en_o), 0);
        chk({tag, "_out_valid"}, 32'(out_valid_o), 0);
        chk({tag, "_sel"},       32'(sel_o), 7);
    endtask

    initial begin
        int  dc0;
        bit  got;
        rst_i   = 1'b1;
        start_i = 1'b0;
        len_i   = '0;
        #12;
        chk_reset_outputs("rst");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);

        // len=1: 1 start + 4 fill + 1 wait + 5 mac + 1 out, done 12 cycles after start
        run_job(1, 12, 0, -1, 0);
        // len=3 continuous: 4 + 3*7 + 1 cycles, results 7 cycles apart
        run_job(3, 26, 1, -1, 0);
        // len=2 with 10-cycle result stall per output: 4 + 2*(1+5+11) + 1
        ready_mode = 2;
        run_job(2, 39, 0, 10, 0);
        ready_mode = 0;
        // len=0: done in the cycle right after start, no samples
        run_job(0, 1, 0, -1, 0);
        // start re-pulsed with a new len mid-job is ignored
        run_job(2, 19, 1, -1, 1);
        // random input and output handshakes
        valid_mode = 1;
        ready_mode = 1;
        run_job(4, -1, 0, -1, 0);
        valid_mode = 0;
        ready_mode = 0;

        // Reset in MAC at tap_cnt=2 (sel=2): asynchronous clear, no done pulse
        @(posedge clk_i);
        #1;
        dc0         = done_count;
        job_samples = 0;
        start_i     = 1'b1;
        len_i       = LEN_W'(2);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        got     = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (sel_o == 3'd2 && acc_en_o) begin
                got = 1;
                break;
            end
        end
        chk("reach_tap2", 32'(got), 1);
        #1;
        rst_i = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        repeat (2) @(posedge clk_i);
        #3;
        rst_i = 1'b0;
        repeat (30) @(posedge clk_i);
        chk("no_done_after_rst", 32'(done_count), 32'(dc0));
        chk("idle_after_rst", 32'(busy_o), 0);

        // Recovery after reset
        run_job(1, 12, 0, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
